// File: rtl/eth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : eth_pkg                                                      |
// | Description : Shared constants for the rx frame checker and the tx FCS     |
// |               path: length limits, CRC constants, header offsets, states.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package eth_pkg;

  localparam int          DEF_MIN_LEN   = 64;
  localparam int          DEF_MAX_LEN   = 1518;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam int          OFS_W         = 11;
  localparam logic [10:0] OFS_MAC_LAST  = 11'd5;
  localparam logic [10:0] OFS_ETYPE     = 11'd12;
  localparam logic [10:0] OFS_TXID      = 11'd14;
  localparam logic [10:0] OFS_AUX       = 11'd15;
  localparam logic [10:0] OFS_SEG       = 11'd16;
  localparam logic [10:0] OFS_PAYLOAD   = 11'd18;

  localparam logic [2:0]  ST_IDLE       = 3'd0;
  localparam logic [2:0]  ST_PREAMBLE   = 3'd1;
  localparam logic [2:0]  ST_HEADER     = 3'd2;
  localparam logic [2:0]  ST_PAYLOAD    = 3'd3;
  localparam logic [2:0]  ST_DROP       = 3'd4;

endpackage
`default_nettype wire

// File: rtl/eth_crc32_d8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_crc32_d8                                                 |
// | Description : Byte-wide reflected CRC32 next-state function (LSB first).   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] w_crc;

  always_comb begin
    w_crc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (w_crc[0] ^ data[i]) w_crc = (w_crc >> 1) ^ CRC_POLY;
      else                    w_crc = w_crc >> 1;
    end
    crc_out = w_crc;
  end

endmodule
`default_nettype wire

// File: rtl/eth_rx_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_rx_frame_checker                                         |
// | Description : Parses video-segment frames from the rx byte stream, streams |
// |               payload minus FCS and issues one good/bad verdict per frame. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module eth_rx_frame_checker
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_MAC    = 48'h00_0A_35_01_02_03,
  parameter bit          CHECK_MAC = 1'b1,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          MIN_LEN   = DEF_MIN_LEN,
  parameter int          MAX_LEN   = DEF_MAX_LEN
)(
  input  logic        clk125MHz,
  input  logic        rstb,
  input  logic [7:0]  data,
  input  logic        data_valid,
  input  logic        data_enable,
  input  logic        data_error,
  output logic        hdr_valid,
  output logic [7:0]  txid,
  output logic [7:0]  aux,
  output logic [15:0] segment_num,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_eof,
  output logic        out_good,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  localparam logic [OFS_W-1:0] c_min_len = OFS_W'(MIN_LEN);
  localparam logic [OFS_W-1:0] c_max_len = OFS_W'(MAX_LEN);

  logic [2:0]       r_state, w_next;
  logic [OFS_W-1:0] r_ofs, w_ofs_inc;
  logic [31:0]      r_crc, w_crc_next;
  logic [3:0][7:0]  r_dl;
  logic [2:0]       r_dl_cnt;
  logic             r_uni_ok, r_bc_ok, r_err, r_too_long;
  logic [7:0]       r_txid_sh, r_aux_sh, r_seg_hi;
  logic [7:0]       w_mac_byte, w_etype_byte;
  logic             w_take, w_uni_hit, w_bc_hit, w_mac_fail, w_etype_fail;
  logic             w_sfd, w_hdr_byte, w_hdr_done, w_pay_byte, w_over, w_emit, w_eof, w_good;

  eth_crc32_d8 u_crc (
    .crc_in  (r_crc),
    .data    (data),
    .crc_out (w_crc_next)
  );

  assign w_take    = data_valid & data_enable;
  assign w_ofs_inc = (r_ofs == '1) ? r_ofs : r_ofs + 1'b1;

  always_comb begin
    w_mac_byte = MY_MAC[7:0];
    case (r_ofs[2:0])
      3'd0:    w_mac_byte = MY_MAC[47:40];
      3'd1:    w_mac_byte = MY_MAC[39:32];
      3'd2:    w_mac_byte = MY_MAC[31:24];
      3'd3:    w_mac_byte = MY_MAC[23:16];
      3'd4:    w_mac_byte = MY_MAC[15:8];
      default: w_mac_byte = MY_MAC[7:0];
    endcase
  end

  // Unicast and broadcast are tracked separately so a frame drops only once neither can still match.
  assign w_uni_hit    = r_uni_ok & (data == w_mac_byte);
  assign w_bc_hit     = r_bc_ok  & (data == 8'hFF);
  assign w_mac_fail   = CHECK_MAC && (r_ofs <= OFS_MAC_LAST) && !w_uni_hit && !w_bc_hit;
  assign w_etype_byte = (r_ofs == OFS_ETYPE) ? ETHERTYPE[15:8] : ETHERTYPE[7:0];
  assign w_etype_fail = ((r_ofs == OFS_ETYPE) || (r_ofs == OFS_ETYPE + 1'b1)) && (data != w_etype_byte);

  always_ff @(posedge clk125MHz or negedge rstb) begin
    if (!rstb) r_state <= ST_DROP;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (data_valid) w_next = ST_PREAMBLE;
      ST_PREAMBLE: begin
        if (!data_valid) w_next = ST_IDLE;
        else if (data_enable) begin
          if (data == SFD_BYTE)           w_next = ST_HEADER;
          else if (data != PREAMBLE_BYTE) w_next = ST_DROP;
        end
      end
      ST_HEADER: begin
        if (!data_valid) w_next = ST_IDLE;
        else if (data_enable) begin
          if (w_mac_fail || w_etype_fail)        w_next = ST_DROP;
          else if (r_ofs == OFS_PAYLOAD - 1'b1)  w_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD:  if (!data_valid) w_next = ST_IDLE;
      ST_DROP:     if (!data_valid) w_next = ST_IDLE;
      default:     w_next = ST_DROP;
    endcase
  end

  always_comb begin
    w_sfd      = (r_state == ST_PREAMBLE) && w_take && (data == SFD_BYTE);
    w_hdr_byte = (r_state == ST_HEADER) && w_take;
    w_hdr_done = w_hdr_byte && !w_mac_fail && !w_etype_fail && (r_ofs == OFS_PAYLOAD - 1'b1);
    w_pay_byte = (r_state == ST_PAYLOAD) && w_take;
    w_over     = r_too_long || (r_ofs >= c_max_len);
    w_emit     = w_pay_byte && !w_over && (r_dl_cnt == 3'd4);
    w_eof      = ((r_state == ST_HEADER) || (r_state == ST_PAYLOAD)) && !data_valid;
    w_good     = (r_state == ST_PAYLOAD) && (r_crc == CRC_RESIDUE) && (r_ofs >= c_min_len)
                 && !r_too_long && !r_err;
  end

  always_ff @(posedge clk125MHz or negedge rstb) begin
    if (!rstb) begin
      r_ofs       <= '0;
      r_crc       <= CRC_INIT;
      r_dl        <= '0;
      r_dl_cnt    <= '0;
      r_uni_ok    <= 1'b0;
      r_bc_ok     <= 1'b0;
      r_err       <= 1'b0;
      r_too_long  <= 1'b0;
      r_txid_sh   <= '0;
      r_aux_sh    <= '0;
      r_seg_hi    <= '0;
      hdr_valid   <= 1'b0;
      txid        <= '0;
      aux         <= '0;
      segment_num <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_eof     <= 1'b0;
      out_good    <= 1'b0;
      frames_ok   <= '0;
      frames_bad  <= '0;
    end else begin
      if (w_sfd) begin
        r_ofs      <= '0;
        r_crc      <= CRC_INIT;
        r_err      <= 1'b0;
        r_too_long <= 1'b0;
        r_uni_ok   <= 1'b1;
        r_bc_ok    <= 1'b1;
      end else if (w_hdr_byte || w_pay_byte) begin
        r_ofs <= w_ofs_inc;
        r_crc <= w_crc_next;
        if (data_error) r_err <= 1'b1;
      end

      if (w_hdr_byte) begin
        if (r_ofs <= OFS_MAC_LAST) begin
          r_uni_ok <= w_uni_hit;
          r_bc_ok  <= w_bc_hit;
        end
        if (r_ofs == OFS_TXID) r_txid_sh <= data;
        if (r_ofs == OFS_AUX)  r_aux_sh  <= data;
        if (r_ofs == OFS_SEG)  r_seg_hi  <= data;
      end

      hdr_valid <= w_hdr_done;
      if (w_hdr_done) begin
        txid        <= r_txid_sh;
        aux         <= r_aux_sh;
        segment_num <= {r_seg_hi, data};
      end

      // Delay line holds back the last four bytes so the FCS never reaches the consumer.
      if (w_sfd || w_eof) begin
        r_dl_cnt <= '0;
      end else if (w_pay_byte) begin
        if (w_over) begin
          r_too_long <= 1'b1;
        end else begin
          r_dl <= {r_dl[2:0], data};
          if (r_dl_cnt != 3'd4) r_dl_cnt <= r_dl_cnt + 3'd1;
        end
      end

      out_valid <= w_emit;
      if (w_emit) out_data <= r_dl[3];

      out_eof  <= w_eof;
      out_good <= w_eof && w_good;
      if (w_eof && w_good && (frames_ok != 16'hFFFF))   frames_ok  <= frames_ok + 16'd1;
      if (w_eof && !w_good && (frames_bad != 16'hFFFF)) frames_bad <= frames_bad + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_eth_rx_frame_checker                                      |
// | Description : Directed frames into eth_rx_frame_checker with expected      |
// |               streams, header fields, verdicts and counters.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_eth_rx_frame_checker;

  logic        clk125MHz = 1'b0;
  logic        rstb = 1'b0;
  logic [7:0]  data = '0;
  logic        data_valid = 1'b0;
  logic        data_enable = 1'b0;
  logic        data_error = 1'b0;
  logic        hdr_valid, out_valid, out_eof, out_good;
  logic [7:0]  txid, aux, out_data;
  logic [15:0] segment_num, frames_ok, frames_bad;

  always #4 clk125MHz = ~clk125MHz;

  eth_rx_frame_checker dut (
    .clk125MHz   (clk125MHz),
    .rstb        (rstb),
    .data        (data),
    .data_valid  (data_valid),
    .data_enable (data_enable),
    .data_error  (data_error),
    .hdr_valid   (hdr_valid),
    .txid        (txid),
    .aux         (aux),
    .segment_num (segment_num),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_eof     (out_eof),
    .out_good    (out_good),
    .frames_ok   (frames_ok),
    .frames_bad  (frames_bad)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  frm[$];
  logic [7:0]  rxq[$];
  int          hdr_cnt, eof_cnt;
  logic        last_good;
  logic [7:0]  cap_txid, cap_aux;
  logic [15:0] cap_seg;

  localparam logic [47:0] c_my_mac  = 48'h00_0A_35_01_02_03;
  localparam logic [47:0] c_bad_mac = 48'h00_0A_35_01_02_04;

  always @(negedge clk125MHz) begin
    if (out_valid) rxq.push_back(out_data);
    if (hdr_valid) begin
      hdr_cnt++;
      cap_txid = txid;
      cap_aux  = aux;
      cap_seg  = segment_num;
    end
    if (out_eof) begin
      eof_cnt++;
      last_good = out_good;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Post-SFD frame of 'tot' bytes: header, payload 0,1,2.., valid FCS; optional bit flip after FCS.
  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] et, input int tot, input int flip);
    logic [31:0] crc;
    int          npay;
    frm.delete();
    for (int k = 5; k >= 0; k--) frm.push_back(dmac[8*k +: 8]);
    frm.push_back(8'h02); frm.push_back(8'h00); frm.push_back(8'h00);
    frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h01);
    frm.push_back(et[15:8]); frm.push_back(et[7:0]);
    frm.push_back(8'h05); frm.push_back(8'h01); frm.push_back(8'h01); frm.push_back(8'h23);
    npay = (tot > 22) ? tot - 22 : 0;
    for (int i = 0; i < npay; i++) frm.push_back(i[7:0]);
    crc = 32'hFFFFFFFF;
    foreach (frm[i]) crc = crc_upd(crc, frm[i]);
    crc = ~crc;
    for (int k = 0; k < 4; k++) frm.push_back(crc[8*k +: 8]);
    if (flip >= 0) frm[18 + flip] = frm[18 + flip] ^ 8'h01;
    while (frm.size() > tot) void'(frm.pop_back());
  endtask

  task automatic step();
    @(posedge clk125MHz);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input logic e, input int pace);
    for (int p = 1; p < pace; p++) begin
      step(); data_valid = 1'b1; data_enable = 1'b0; data = 8'h00; data_error = 1'b0;
    end
    step(); data_valid = 1'b1; data_enable = 1'b1; data = b; data_error = e;
  endtask

  task automatic send_frame(input int pace, input int err_pos, input int rst_pos, input int gap);
    for (int k = 0; k < 8; k++) put((k == 7) ? 8'hD5 : 8'h55, 1'b0, pace);
    foreach (frm[i]) begin
      if (i == rst_pos) begin
        step(); data_enable = 1'b0; rstb = 1'b0;
        repeat (3) step();
        rstb = 1'b1;
      end
      put(frm[i], (i == err_pos), pace);
    end
    for (int g = 0; g < gap; g++) begin
      step(); data_valid = 1'b0; data_enable = 1'b0; data = 8'h00; data_error = 1'b0;
    end
  endtask

  task automatic clear();
    rxq.delete();
    hdr_cnt = 0;
    eof_cnt = 0;
    last_good = 1'b0;
  endtask

  function automatic int seq_err(input int flip);
    int bad = 0;
    foreach (rxq[i]) if (rxq[i] !== ((i == flip) ? (i[7:0] ^ 8'h01) : i[7:0])) bad++;
    return bad;
  endfunction

  initial begin
    clear();
    repeat (3) step();
    @(negedge clk125MHz);
    chk("rst_ok",    frames_ok,  0);
    chk("rst_bad",   frames_bad, 0);
    chk("rst_eof",   out_eof,    0);
    chk("rst_oval",  out_valid,  0);
    chk("rst_hdr",   hdr_valid,  0);
    chk("rst_seg",   segment_num, 0);
    step(); rstb = 1'b1;
    repeat (3) step();

    // Good 100-byte frame
    clear(); build_frame(c_my_mac, 16'h88B5, 100, -1); send_frame(1, -1, -1, 12);
    chk("t1_hdrcnt", hdr_cnt, 1);
    chk("t1_txid",   cap_txid, 8'h05);
    chk("t1_aux",    cap_aux,  8'h01);
    chk("t1_seg",    cap_seg,  16'h0123);
    chk("t1_nbytes", rxq.size(), 78);
    chk("t1_seq",    seq_err(-1), 0);
    chk("t1_eof",    eof_cnt, 1);
    chk("t1_good",   last_good, 1);
    chk("t1_ok",     frames_ok, 1);
    chk("t1_bad",    frames_bad, 0);

    // Corrupted payload byte 40
    clear(); build_frame(c_my_mac, 16'h88B5, 100, 40); send_frame(1, -1, -1, 12);
    chk("t2_nbytes", rxq.size(), 78);
    chk("t2_seq",    seq_err(40), 0);
    chk("t2_eof",    eof_cnt, 1);
    chk("t2_good",   last_good, 0);
    chk("t2_bad",    frames_bad, 1);

    // Filtered: wrong ethertype, then wrong MAC
    clear(); build_frame(c_my_mac, 16'h0800, 100, -1); send_frame(1, -1, -1, 12);
    build_frame(c_bad_mac, 16'h88B5, 100, -1); send_frame(1, -1, -1, 12);
    chk("t3_hdr",    hdr_cnt, 0);
    chk("t3_nbytes", rxq.size(), 0);
    chk("t3_eof",    eof_cnt, 0);
    chk("t3_ok",     frames_ok, 1);
    chk("t3_bad",    frames_bad, 1);

    // 1-of-10 enable pacing
    clear(); build_frame(c_my_mac, 16'h88B5, 100, -1); send_frame(10, -1, -1, 12);
    chk("t4_nbytes", rxq.size(), 78);
    chk("t4_seq",    seq_err(-1), 0);
    chk("t4_good",   last_good, 1);
    chk("t4_ok",     frames_ok, 2);

    // data_error on payload byte 10
    clear(); build_frame(c_my_mac, 16'h88B5, 100, -1); send_frame(1, 28, -1, 12);
    chk("t5_err_eof",  eof_cnt, 1);
    chk("t5_err_good", last_good, 0);
    chk("t5_err_bad",  frames_bad, 2);

    // 40-byte runt with valid FCS
    clear(); build_frame(c_my_mac, 16'h88B5, 40, -1); send_frame(1, -1, -1, 12);
    chk("t5_runt_eof",  eof_cnt, 1);
    chk("t5_runt_good", last_good, 0);
    chk("t5_runt_bad",  frames_bad, 3);

    // 20-byte runt: too short to fill the delay line
    clear(); build_frame(c_my_mac, 16'h88B5, 20, -1); send_frame(1, -1, -1, 12);
    chk("t5_r20_nbytes", rxq.size(), 0);
    chk("t5_r20_good",   last_good, 0);
    chk("t5_r20_bad",    frames_bad, 4);

    // 1600-byte oversize frame
    clear(); build_frame(c_my_mac, 16'h88B5, 1600, -1); send_frame(1, -1, -1, 12);
    chk("t5_long_max",  (rxq.size() <= 1496), 1);
    chk("t5_long_eof",  eof_cnt, 1);
    chk("t5_long_good", last_good, 0);
    chk("t5_long_bad",  frames_bad, 5);

    // Back-to-back frames with a single idle cycle
    clear(); build_frame(c_my_mac, 16'h88B5, 100, -1);
    send_frame(1, -1, -1, 1); send_frame(1, -1, -1, 12);
    chk("b2b_eof",    eof_cnt, 2);
    chk("b2b_good",   last_good, 1);
    chk("b2b_nbytes", rxq.size(), 156);
    chk("b2b_ok",     frames_ok, 4);

    // Reset mid-payload, released with data_valid still high
    clear(); build_frame(c_my_mac, 16'h88B5, 100, -1); send_frame(1, -1, 50, 12);
    chk("t6_eof", eof_cnt, 0);
    chk("t6_ok",  frames_ok, 0);
    chk("t6_bad", frames_bad, 0);
    clear(); send_frame(1, -1, -1, 12);
    chk("t6_clean_eof",  eof_cnt, 1);
    chk("t6_clean_good", last_good, 1);
    chk("t6_clean_seq",  seq_err(-1), 0);
    chk("t6_clean_ok",   frames_ok, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
